// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and handshake controller for a synchronous FIFO built around a
// dual-port RAM on the same clock. Flags come from registers only; no fall-through.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic                  clr_err,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

    // Pointers carry an extra wrap bit; only the low bits address the RAM.
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_almost_full;
    logic                r_almost_empty;
    logic                r_rd_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDR_WIDTH:0] w_wr_ptr_next;
    logic [ADDR_WIDTH:0] w_rd_ptr_next;
    logic [ADDR_WIDTH:0] w_count_next;
    logic                w_full_next;
    logic                w_empty_next;
    logic                w_almost_full_next;
    logic                w_almost_empty_next;
    logic                w_overflow_next;
    logic                w_underflow_next;

    // Accept decision from registered flags; requests are ignored while in reset.
    always_comb begin
        w_wr_acc = 1'b0;
        w_rd_acc = 1'b0;
        if (reset) begin
            w_wr_acc = wr_req & ~r_full;
            w_rd_acc = rd_req & ~r_empty;
        end else begin
            w_wr_acc = 1'b0;
            w_rd_acc = 1'b0;
        end
    end

    // Next pointers and occupancy.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_wr_acc) begin
            w_wr_ptr_next = r_wr_ptr + C_ONE;
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end
        if (w_rd_acc) begin
            w_rd_ptr_next = r_rd_ptr + C_ONE;
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end
        w_count_next = r_count
                     + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                     - {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    end

    // Status flags derived from the occupancy that will hold after this edge.
    always_comb begin
        w_full_next         = (w_count_next == C_DEPTH);
        w_empty_next        = (w_count_next == C_ZERO);
        w_almost_full_next  = (w_count_next >= C_AF);
        w_almost_empty_next = (w_count_next <= C_AE);
    end

    // Sticky error flags; a new error in the clearing cycle wins over clr_err.
    always_comb begin
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;
        if (wr_req & r_full) begin
            w_overflow_next = 1'b1;
        end else if (clr_err) begin
            w_overflow_next = 1'b0;
        end else begin
            w_overflow_next = r_overflow;
        end
        if (rd_req & r_empty) begin
            w_underflow_next = 1'b1;
        end else if (clr_err) begin
            w_underflow_next = 1'b0;
        end else begin
            w_underflow_next = r_underflow;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= C_ZERO;
            r_rd_ptr <= C_ZERO;
            r_count  <= C_ZERO;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_full         <= w_full_next;
            r_empty        <= w_empty_next;
            r_almost_full  <= w_almost_full_next;
            r_almost_empty <= w_almost_empty_next;
        end
    end

    // Read-valid strobe (aligned with RAM dout) and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    assign mem_we       = w_wr_acc;
    assign mem_re       = w_rd_acc;
    assign wr_ptr       = r_wr_ptr[ADDR_WIDTH-1:0];
    assign rd_ptr       = r_rd_ptr[ADDR_WIDTH-1:0];
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (depth 4) with a small behavioural RAM
// attached so data order through the controller's pointers can be checked.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset, wr_req, rd_req, clr_err;
    logic       mem_we, mem_re, full, empty, almost_full, almost_empty;
    logic       rd_valid, overflow, underflow;
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic [7:0] din, dout;
    logic [7:0] ram [0:3];
    int total = 0;
    int bad   = 0;

    sync_fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .mem_we(mem_we), .mem_re(mem_re), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Storage RAM model driven by the controller.
    always @(posedge clk) begin
        if (mem_we) ram[wr_ptr] <= din;
        if (mem_re) dout <= ram[rd_ptr];
    end

    task automatic test_reset;
        reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almost_full); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b exp=0", rd_valid); end
        total++; if (wr_ptr !== 2'd0 || rd_ptr !== 2'd0) begin bad++; $display("FAIL rst_ptrs got=%0d/%0d exp=0/0", wr_ptr, rd_ptr); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", overflow, underflow); end
        wr_req = 1'b1; rd_req = 1'b1; #1;
        total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL rst_gate got=%b%b exp=00", mem_we, mem_re); end
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL idle got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_fill;
        logic [2:0] c;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; din = 8'hA0 + 8'(i); #1;
            total++; if (mem_we !== 1'b1 || wr_ptr !== 2'(i)) begin bad++; $display("FAIL fill_we%0d got=%b/%0d exp=1/%0d", i, mem_we, wr_ptr, i); end
            @(negedge clk);
            c = 3'(i + 1);
            total++; if (count !== c) begin bad++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, c); end
            total++; if (full !== (c == 3'd4)) begin bad++; $display("FAIL fill_full%0d got=%b exp=%b", i, full, c == 3'd4); end
            total++; if (almost_full !== (c >= 3'd3)) begin bad++; $display("FAIL fill_af%0d got=%b exp=%b", i, almost_full, c >= 3'd3); end
            total++; if (almost_empty !== (c <= 3'd1)) begin bad++; $display("FAIL fill_ae%0d got=%b exp=%b", i, almost_empty, c <= 3'd1); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty%0d got=%b exp=0", i, empty); end
        end
        wr_req = 1'b1; din = 8'hFF; #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ovf_we got=%b exp=0", mem_we); end
        @(negedge clk); wr_req = 1'b0;
        total++; if (overflow !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL ovf got=%b/%0d exp=1/4", overflow, count); end
    endtask

    task automatic test_drain;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; #1;
            total++; if (mem_re !== 1'b1 || rd_ptr !== 2'(i)) begin bad++; $display("FAIL drain_re%0d got=%b/%0d exp=1/%0d", i, mem_re, rd_ptr, i); end
            @(negedge clk);
            e = 8'hA0 + 8'(i);
            total++; if (rd_valid !== 1'b1 || dout !== e) begin bad++; $display("FAIL drain_data%0d got=%b/%h exp=1/%h", i, rd_valid, dout, e); end
            total++; if (count !== 3'(3 - i) || empty !== (i == 3)) begin bad++; $display("FAIL drain_cnt%0d got=%0d/%b exp=%0d/%b", i, count, empty, 3 - i, i == 3); end
        end
        rd_req = 1'b1; #1;
        total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL udf_re got=%b exp=0", mem_re); end
        @(negedge clk); rd_req = 1'b0;
        total++; if (underflow !== 1'b1 || overflow !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL udf got=%b%b%b exp=110", underflow, overflow, rd_valid); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL clr_err got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; din = 8'hB0 + 8'(i); @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            wr_req = 1'b1; rd_req = 1'b1; din = 8'hB2 + 8'(k); #1;
            total++; if (mem_we !== 1'b1 || mem_re !== 1'b1 || wr_ptr !== 2'(k + 2) || rd_ptr !== 2'(k)) begin
                bad++; $display("FAIL wrap_ptr%0d got=%b%b/%0d/%0d exp=11/%0d/%0d", k, mem_we, mem_re, wr_ptr, rd_ptr, (k + 2) % 4, k % 4); end
            @(negedge clk);
            e = 8'hB0 + 8'(k);
            total++; if (rd_valid !== 1'b1 || dout !== e) begin bad++; $display("FAIL wrap_data%0d got=%b/%h exp=1/%h", k, rd_valid, dout, e); end
            total++; if (count !== 3'd2 || full !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL wrap_cnt%0d got=%0d/%b%b exp=2/00", k, count, full, empty); end
        end
        wr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_req = 1'b1; @(negedge clk);
            e = 8'hB6 + 8'(i);
            total++; if (dout !== e) begin bad++; $display("FAIL wrap_tail%0d got=%h exp=%h", i, dout, e); end
        end
        rd_req = 1'b0;
        total++; if (empty !== 1'b1 || count !== 3'd0 || wr_ptr !== 2'd0 || rd_ptr !== 2'd0) begin
            bad++; $display("FAIL wrap_end got=%b/%0d/%0d/%0d exp=1/0/0/0", empty, count, wr_ptr, rd_ptr); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; din = 8'hC0 + 8'(i); @(negedge clk);
        end
        wr_req = 1'b1; rd_req = 1'b1; din = 8'hC2; #1;
        total++; if (mem_we !== 1'b1 || mem_re !== 1'b1) begin bad++; $display("FAIL sim2_en got=%b%b exp=11", mem_we, mem_re); end
        @(negedge clk);
        total++; if (count !== 3'd2 || wr_ptr !== 2'd3 || rd_ptr !== 2'd1 || dout !== 8'hC0) begin
            bad++; $display("FAIL sim2 got=%0d/%0d/%0d/%h exp=2/3/1/c0", count, wr_ptr, rd_ptr, dout); end
        rd_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = 8'hC3 + 8'(i); @(negedge clk);
        end
        total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL sim_fill got=%b/%0d exp=1/4", full, count); end
        rd_req = 1'b1; din = 8'hEE; #1;
        total++; if (mem_we !== 1'b0 || mem_re !== 1'b1) begin bad++; $display("FAIL simf_en got=%b%b exp=01", mem_we, mem_re); end
        @(negedge clk);
        total++; if (count !== 3'd3 || overflow !== 1'b1 || full !== 1'b0 || dout !== 8'hC1) begin
            bad++; $display("FAIL simf got=%0d/%b/%b/%h exp=3/1/0/c1", count, overflow, full, dout); end
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        total++; if (empty !== 1'b1 || dout !== 8'hC4) begin bad++; $display("FAIL sim_drain got=%b/%h exp=1/c4", empty, dout); end
        wr_req = 1'b1; din = 8'hC5; #1;
        total++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin bad++; $display("FAIL sime_en got=%b%b exp=10", mem_we, mem_re); end
        @(negedge clk);
        total++; if (count !== 3'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
            bad++; $display("FAIL sime got=%0d/%b/%b/%b exp=1/1/0/0", count, underflow, rd_valid, empty); end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_mid_reset;
        wr_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = 8'hD0 + 8'(i); @(negedge clk);
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mr_pre got=%0d exp=3", count); end
        rd_req = 1'b1; #1; reset = 1'b0; #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            bad++; $display("FAIL mr_flags got=%0d/%b%b%b%b exp=0/1010", count, empty, full, almost_empty, almost_full); end
        total++; if (wr_ptr !== 2'd0 || rd_ptr !== 2'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL mr_regs got=%0d/%0d/%b%b%b exp=0/0/000", wr_ptr, rd_ptr, rd_valid, overflow, underflow); end
        total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL mr_gate got=%b%b exp=00", mem_we, mem_re); end
        @(negedge clk); wr_req = 1'b0; reset = 1'b1; #1;
        total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL mr_rd got=%b exp=0", mem_re); end
        @(negedge clk); rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || underflow !== 1'b1) begin
            bad++; $display("FAIL mr_post got=%b/%0d/%b/%b exp=0/0/1/1", rd_valid, count, empty, underflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
